// File: rtl/pc_exc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_exc_ctrl
//   Program-counter register with a small exception sequencer. On an
//   exception request the block saves pc - 4 into epc, fetches one vector byte
//   from memory at address (VEC_BASE + source index) and loads it into pc.
//
// Configuration macro:
//   PC_EXC_ERET_EN - when defined, eret in IDLE restores pc from epc.
//                    When undefined, eret is ignored.
//
// Parameters:
//   DATA_W   - width of pc / epc / pc_next / mem_addr (at least 8)
//   N_EXC    - number of exception sources
//   VEC_BASE - vector byte address of source 0
//   MEM_LAT  - memory read latency in cycles (1..15)
//
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   pc_next        - next-PC value from the datapath
//   pc_write       - load pc_next into pc (IDLE only)
//   exc_req        - exception request vector, lowest index wins
//   eret           - return from exception (see PC_EXC_ERET_EN)
//   mem_rdata      - vector byte returned by memory
//   mem_addr       - vector address, non-zero only in FETCH
//   mem_rd         - read strobe, high for MEM_LAT cycles in FETCH
//   pc, epc        - current PC and saved exception PC
//   cause          - code of the last taken exception (VEC_BASE + index)
//   busy           - exception sequence in progress
//   exc_ack        - one-cycle pulse in the cycle pc shows the handler value
//
// Handshake: there is no valid/ready pair. exc_req is level-sampled only in
// IDLE; while busy all requests, eret and pc_write are ignored, and a request
// still held when the sequence returns to IDLE is taken on that cycle.
// -----------------------------------------------------------------------------
module pc_exc_ctrl #(
  parameter int DATA_W   = 32,
  parameter int N_EXC    = 3,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              pc_write,
  input  logic [N_EXC-1:0]  exc_req,
  input  logic              eret,
  input  logic [7:0]        mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] epc,
  output logic [7:0]        cause,
  output logic              busy,
  output logic              exc_ack
);

  // Reject configurations whose vector table does not fit in one byte of
  // address space or whose latency cannot be counted.
  if ((VEC_BASE + N_EXC - 1 > 255) || (VEC_BASE < 0) || (N_EXC < 1) ||
      (MEM_LAT < 1) || (MEM_LAT > 15) || (DATA_W < 8)) begin : g_bad_params
    $error("pc_exc_ctrl: illegal parameters (VEC_BASE+N_EXC-1 must be <= 255, MEM_LAT in 1..15)");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_FETCH = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [7:0]        cause_q, cause_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              exc_ack_q, exc_ack_d;

  logic              exc_any;
  logic [7:0]        exc_code;
  logic              eret_take;

`ifdef PC_EXC_ERET_EN
  assign eret_take = eret;
`else
  logic unused_eret;
  assign unused_eret = eret;
  assign eret_take   = 1'b0;
`endif

  // Lowest set index wins: scanning downward leaves the lowest hit last.
  always_comb begin
    exc_any  = |exc_req;
    exc_code = 8'd0;
    for (int i = N_EXC - 1; i >= 0; i--) begin
      if (exc_req[i]) exc_code = 8'(VEC_BASE + i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
      exc_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      exc_ack_q <= exc_ack_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (exc_any) state_d = ST_SAVE;
      ST_SAVE:  state_d = ST_FETCH;
      ST_FETCH: if (cnt_q == LAST_CNT) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath register updates
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    exc_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Priority: exception > eret > pc_write. pc is frozen when an
        // exception is taken.
        if (exc_any)        cause_d = exc_code;
        else if (eret_take) pc_d    = epc_q;
        else if (pc_write)  pc_d    = pc_next;
      end
      ST_SAVE: begin
        epc_d = pc_q - DATA_W'(4);
        cnt_d = '0;
      end
      ST_FETCH: begin
        if (cnt_q != LAST_CNT) cnt_d = cnt_q + 4'd1;
      end
      ST_LOAD: begin
        // mem_rdata holds the byte read during FETCH; exc_ack is registered
        // so it lines up with the cycle pc shows the handler address.
        pc_d      = DATA_W'(mem_rdata);
        exc_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q != ST_IDLE);
    mem_rd   = (state_q == ST_FETCH);
    mem_addr = mem_rd ? DATA_W'(cause_q) : '0;
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign exc_ack = exc_ack_q;

endmodule

// File: tb/tb_pc_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_exc_ctrl
//   Self-checking bench for pc_exc_ctrl. Two instances: dut (MEM_LAT = 1) and
//   dut3 (MEM_LAT = 3). A small registered memory model returns vector bytes.
//   Expected exception results are pushed to scoreboard queues when a request
//   is driven and popped when exc_ack is observed.
// -----------------------------------------------------------------------------
module tb_pc_exc_ctrl;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut (MEM_LAT = 1) ----------------
  logic [31:0] pc_next   = '0;
  logic        pc_write  = 1'b0;
  logic [2:0]  exc_req   = '0;
  logic        eret      = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [31:0] mem_addr, pc, epc;
  logic        mem_rd, busy, exc_ack;
  logic [7:0]  cause;

  pc_exc_ctrl #(.DATA_W(32), .N_EXC(3), .VEC_BASE(253), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .exc_req(exc_req), .eret(eret), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .pc(pc), .epc(epc),
    .cause(cause), .busy(busy), .exc_ack(exc_ack)
  );

  // ---------------- dut3 (MEM_LAT = 3) ----------------
  logic [31:0] pc_next3   = '0;
  logic        pc_write3  = 1'b0;
  logic [2:0]  exc_req3   = '0;
  logic        eret3      = 1'b0;
  logic [7:0]  mem_rdata3 = 8'h00;
  logic [31:0] mem_addr3, pc3, epc3;
  logic        mem_rd3, busy3, exc_ack3;
  logic [7:0]  cause3;

  pc_exc_ctrl #(.DATA_W(32), .N_EXC(3), .VEC_BASE(253), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .pc_next(pc_next3), .pc_write(pc_write3),
    .exc_req(exc_req3), .eret(eret3), .mem_rdata(mem_rdata3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .pc(pc3), .epc(epc3),
    .cause(cause3), .busy(busy3), .exc_ack(exc_ack3)
  );

  // ---------------- memory model ----------------
  function automatic logic [7:0] vec_byte(input logic [31:0] addr);
    case (addr)
      32'd253: return 8'h20;
      32'd254: return 8'h80;
      32'd255: return 8'hC4;
      default: return 8'hEE;
    endcase
  endfunction

  // Registered read: the byte appears the cycle after the strobe and holds.
  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= vec_byte(mem_addr);
    if (mem_rd3) mem_rdata3 <= vec_byte(mem_addr3);
  end

  // ---------------- observation mux ----------------
  logic sel3 = 1'b0;
  wire [31:0] o_pc       = sel3 ? pc3       : pc;
  wire [31:0] o_epc      = sel3 ? epc3      : epc;
  wire [31:0] o_mem_addr = sel3 ? mem_addr3 : mem_addr;
  wire [7:0]  o_cause    = sel3 ? cause3    : cause;
  wire        o_mem_rd   = sel3 ? mem_rd3   : mem_rd;
  wire        o_busy     = sel3 ? busy3     : busy;
  wire        o_exc_ack  = sel3 ? exc_ack3  : exc_ack;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];        // expected pc after a pc_write / eret
  logic [31:0] exp_pc_q[$];     // expected handler pc per exception
  logic [31:0] exp_epc_q[$];
  logic [7:0]  exp_cause_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lowest_code(input logic [2:0] req);
    if (req[0])      return 8'd253;
    else if (req[1]) return 8'd254;
    else             return 8'd255;
  endfunction

  task automatic expect_exc(input logic [31:0] cur_pc, input logic [2:0] req);
    logic [7:0] code;
    code = lowest_code(req);
    exp_cause_q.push_back(code);
    exp_epc_q.push_back(cur_pc - 32'd4);
    exp_pc_q.push_back({24'd0, vec_byte({24'd0, code})});
  endtask

  task automatic write_pc(input logic [31:0] v);
    if (sel3) begin pc_next3 = v; pc_write3 = 1'b1; end
    else      begin pc_next  = v; pc_write  = 1'b1; end
    exp_q.push_back(v);
    step();
    pc_write = 1'b0; pc_write3 = 1'b0;
    n_checks++;
    if (o_pc !== exp_q[0]) begin
      n_fail++; $display("FAIL pc_write: pc=%h expected %h", o_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  // Drive a request and follow the sequence to exc_ack. keep=1 leaves the
  // request asserted so the next sequence starts straight after the ack.
  task automatic run_exc(input logic [2:0] req, input bit keep,
                         input logic [7:0] exp_addr, input int lat_exp,
                         input logic [31:0] hold_pc);
    int lat;
    int rd_n;
    bit got;
    lat = 0; rd_n = 0; got = 1'b0;
    if (sel3) exc_req3 = req; else exc_req = req;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (lat == 1 && !keep) begin exc_req = '0; exc_req3 = '0; end
      if (o_mem_rd) begin
        rd_n++;
        n_checks++;
        if (o_mem_addr !== {24'd0, exp_addr}) begin
          n_fail++; $display("FAIL fetch_addr: mem_addr=%h expected %h", o_mem_addr, exp_addr);
        end
      end else begin
        n_checks++;
        if (o_mem_addr !== 32'd0) begin
          n_fail++; $display("FAIL idle_addr: mem_addr=%h expected 0", o_mem_addr);
        end
      end
      if (o_exc_ack) got = 1'b1;
      else begin
        n_checks++;
        if (o_pc !== hold_pc || o_busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_hold: pc=%h busy=%b expected pc=%h busy=1", o_pc, o_busy, hold_pc);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL ack_timeout: no exc_ack after %0d cycles", lat);
    end
    n_checks++;
    if (lat != lat_exp || rd_n != lat_exp - 3) begin
      n_fail++; $display("FAIL latency: ack after %0d cycles with %0d reads, expected %0d and %0d",
                         lat, rd_n, lat_exp, lat_exp - 3);
    end
    n_checks++;
    if (exp_pc_q.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty: exc_ack with nothing expected");
    end else begin
      if (o_pc !== exp_pc_q[0] || o_epc !== exp_epc_q[0] || o_cause !== exp_cause_q[0] || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL handler: pc=%h epc=%h cause=%0d busy=%b expected pc=%h epc=%h cause=%0d busy=0",
                           o_pc, o_epc, o_cause, o_busy, exp_pc_q[0], exp_epc_q[0], exp_cause_q[0]);
      end
      void'(exp_pc_q.pop_front()); void'(exp_epc_q.pop_front()); void'(exp_cause_q.pop_front());
    end
    if (!keep) begin
      pc_write = 1'b0; pc_write3 = 1'b0; eret = 1'b0; eret3 = 1'b0;
      step();
      n_checks++;
      if (o_exc_ack !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL ack_pulse: exc_ack=%b busy=%b expected 0 0", o_exc_ack, o_busy);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_values(input string tag);
    n_checks++;
    if (o_pc !== 32'd0 || o_epc !== 32'd0 || o_cause !== 8'd0 || o_busy !== 1'b0 ||
        o_exc_ack !== 1'b0 || o_mem_rd !== 1'b0 || o_mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL %s: pc=%h epc=%h cause=%0d busy=%b ack=%b rd=%b addr=%h expected all zero",
               tag, o_pc, o_epc, o_cause, o_busy, o_exc_ack, o_mem_rd, o_mem_addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      sel3 = s[0];
      #0;
      check_reset_values("reset_state");
    end
    sel3  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_pc_write();
    sel3 = 1'b0;
    write_pc(32'h0000_0040);
    n_checks++;
    if (o_busy !== 1'b0 || o_epc !== 32'd0) begin
      n_fail++; $display("FAIL first_write: busy=%b epc=%h expected 0 0", o_busy, o_epc);
    end
    for (int i = 0; i < 4; i++) write_pc($urandom);
    // pc_write low: pc holds
    exp_q.push_back(o_pc);
    pc_next = $urandom;
    step();
    n_checks++;
    if (o_pc !== exp_q[0]) begin
      n_fail++; $display("FAIL pc_hold: pc=%h expected %h", o_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
    write_pc(32'h0000_0044);
  endtask

  task automatic test_exception();
    sel3 = 1'b0;
    expect_exc(32'h44, 3'b110);
    run_exc(3'b110, 1'b0, 8'd254, 4, 32'h44);
  endtask

  task automatic test_priority();
    sel3 = 1'b0;
    pc_next  = 32'hDEAD_0000;
    pc_write = 1'b1;
    expect_exc(32'h80, 3'b001);
    run_exc(3'b001, 1'b0, 8'd253, 4, 32'h80);
    n_checks++;
    if (o_pc !== 32'h20) begin
      n_fail++; $display("FAIL pc_write_ignored: pc=%h expected 00000020", o_pc);
    end
  endtask

  task automatic test_random_exc();
    logic [31:0] p;
    logic [2:0]  r;
    sel3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = (i == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      r = 3'($urandom_range(1, 7));
      write_pc(p);
      expect_exc(p, r);
      run_exc(r, 1'b0, lowest_code(r), 4, p);
    end
  endtask

  task automatic test_reset_mid();
    sel3 = 1'b0;
    write_pc(32'h0000_0100);
    exc_req = 3'b001;
    step();
    exc_req = 3'b000;
    step();
    n_checks++;
    if (o_mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL in_fetch: mem_rd=%b expected 1", o_mem_rd);
    end
    reset = 1'b1;
    step();
    check_reset_values("reset_mid");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (o_exc_ack !== 1'b0 || o_pc !== 32'd0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL after_abort: ack=%b pc=%h busy=%b expected 0 0 0", o_exc_ack, o_pc, o_busy);
      end
    end
  endtask

  task automatic test_eret();
    logic [31:0] cur;
    sel3 = 1'b0;
    write_pc(32'h0000_0044);
    expect_exc(32'h44, 3'b010);
    run_exc(3'b010, 1'b0, 8'd254, 4, 32'h44);
    // eret with pc_write in the same cycle
    eret = 1'b1; pc_write = 1'b1; pc_next = 32'h0000_1234;
`ifdef PC_EXC_ERET_EN
    exp_q.push_back(32'h40);
`else
    exp_q.push_back(32'h1234);
`endif
    step();
    eret = 1'b0; pc_write = 1'b0;
    n_checks++;
    if (o_pc !== exp_q[0]) begin
      n_fail++; $display("FAIL eret_vs_write: pc=%h expected %h", o_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
    // eret alone
    write_pc(32'h0000_0300);
    eret = 1'b1;
`ifdef PC_EXC_ERET_EN
    exp_q.push_back(32'h40);
`else
    exp_q.push_back(32'h300);
`endif
    step();
    n_checks++;
    if (o_pc !== exp_q[0]) begin
      n_fail++; $display("FAIL eret_alone: pc=%h expected %h", o_pc, exp_q[0]);
    end
    cur = exp_q.pop_front();
    // exception beats eret held high; eret stays ignored while busy
    expect_exc(cur, 3'b100);
    run_exc(3'b100, 1'b0, 8'd255, 4, cur);
  endtask

  task automatic test_back_to_back();
    sel3 = 1'b1;
    write_pc(32'h0000_0200);
    expect_exc(32'h200, 3'b100);
    expect_exc(32'hC4, 3'b100);
    run_exc(3'b100, 1'b1, 8'd255, 6, 32'h200);
    run_exc(3'b100, 1'b0, 8'd255, 6, 32'hC4);
    sel3 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_pc_write();
    test_exception();
    test_priority();
    test_random_exc();
    test_reset_mid();
    test_eret();
    test_back_to_back();
    n_checks++;
    if (exp_pc_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d exceptions and %0d writes left, expected 0 0",
                         exp_pc_q.size(), exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_exc_ctrl.md
PC_EXC_CTRL -- requirements
Module: pc_exc_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
- DATA_W, 32, width of PC/EPC/next-PC datapath.
- N_EXC, 3, number of exception sources.
- VEC_BASE, 253, memory byte address of the vector for source 0.
- MEM_LAT, 1, memory read latency in cycles, 1..15.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high reset.
- pc_next, in, DATA_W, next-PC value selected by the datapath.
- pc_write, in, 1, load pc_next into PC.
- exc_req, in, N_EXC, exception request vector, level-sampled.
- eret, in, 1, return-from-exception request.
- mem_rdata, in, 8, byte returned by memory.
- mem_addr, out, DATA_W, vector byte address during fetch.
- mem_rd, out, 1, memory read strobe.
- pc, out, DATA_W, current PC.
- epc, out, DATA_W, saved exception PC.
- cause, out, 8, code of the last taken exception (VEC_BASE + index).
- busy, out, 1, exception sequence in progress.
- exc_ack, out, 1, one-cycle pulse when the handler PC is loaded.

Function
REQ-003 The FSM SHALL have the states IDLE, SAVE, FETCH, and LOAD, encoded internally.
REQ-004 In IDLE with exc_req != 0, the block SHALL select the lowest set index i, latch cause = VEC_BASE + i, and go to SAVE; pc SHALL be unchanged that cycle.
REQ-005 In SAVE, the block SHALL load epc <= pc - 4 (modulo 2^DATA_W), reset the latency counter, and go to FETCH.
REQ-006 In FETCH, the block SHALL drive mem_rd = 1 and mem_addr = zero-extended cause, hold them for MEM_LAT cycles, then go to LOAD.
REQ-007 In LOAD, the block SHALL load pc <= {zeros, mem_rdata}, pulse exc_ack = 1 for this cycle only, and return to IDLE.
REQ-008 Exception latency, from the exc_req sample to pc updated, SHALL be MEM_LAT + 3 cycles.
REQ-009 busy SHALL be 1 in SAVE, FETCH and LOAD, and 0 in IDLE.
REQ-010 While busy, pc_write, eret and exc_req SHALL be ignored; requests still asserted on return to IDLE SHALL be taken then.
REQ-011 In IDLE with exc_req == 0 and pc_write = 1, the block SHALL load pc <= pc_next.
REQ-012 Priority in IDLE SHALL be exc_req > eret > pc_write.
REQ-013 mem_rd SHALL be 0 and mem_addr SHALL be 0 outside FETCH.
REQ-014 Nested exceptions SHALL NOT be supported; epc SHALL be overwritten by each taken exception.
REQ-015 A design where VEC_BASE + N_EXC - 1 > 255 or MEM_LAT = 0 SHALL be rejected at elaboration.

Reset
REQ-016 When reset = 1 at a clock edge, the block SHALL set pc = 0, epc = 0, cause = 0, state = IDLE, counter = 0, mem_rd = 0, mem_addr = 0, busy = 0, and exc_ack = 0.
REQ-017 Reset asserted mid-sequence SHALL abort the sequence with no pc or epc update and no exc_ack.
REQ-018 Reset SHALL take precedence over all other inputs.

Configuration
REQ-019 Macro PC_EXC_ERET_EN SHALL control the eret path.
REQ-020 With PC_EXC_ERET_EN defined, eret in IDLE (no exc_req) SHALL load pc <= epc in one cycle, overriding pc_write.
REQ-021 With PC_EXC_ERET_EN undefined, eret SHALL be ignored and pc_write behaviour SHALL be unchanged.

Verification
REQ-022 Reset, then pc_write = 1 with pc_next = 0x00000040 -> pc = 0x40 the next cycle, busy = 0, epc = 0.
REQ-023 pc = 0x44, exc_req = 3'b110, MEM_LAT = 1 -> cause = 254, epc = 0x40, mem_addr = 254 with mem_rd for 1 cycle, mem_rdata = 0x80 -> pc = 0x80 and an exc_ack pulse 4 cycles after the request.
REQ-024 exc_req = 3'b001 and pc_write = 1 in the same cycle -> pc_next is ignored, cause = 253, and pc_write is ignored for the whole sequence while busy = 1.
REQ-025 Reset asserted during FETCH -> the next cycle shows all outputs at reset values and no exc_ack.
REQ-026 PC_EXC_ERET_EN defined, epc = 0x40, eret = 1 and pc_write = 1 -> pc = 0x40; undefined -> pc = pc_next.
REQ-027 MEM_LAT = 3 with a sustained exc_req[2] -> mem_rd held for 3 cycles at address 255, and a second sequence starting immediately after exc_ack.
